fpu_float_to_int: RTL and testbench

Pipelined FP32-to-integer converter implementing RISC-V `fcvt.w.s` / `fcvt.wu.s` semantics. It is the inverse of the FPU's normalizing (leading-zero / left-shift) path: it denormalizes a binary32 operand by right-shifting it, collects guard and sticky bits, rounds, and saturates to a 32-bit integer with exception flags. It sits beside the FPU add/mul units behind the same valid/ready stream interface.

---
 rtl/fpu_float_to_int.sv | 184 ++++++++++++++++++
 tb/tb_fpu_float_to_int.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_float_to_int.sv
// rtl/fpu_float_to_int.sv - two-stage FP32 to 32-bit integer converter (fcvt.w.s / fcvt.wu.s)
// Define FPU_CVT_UNSIGNED_EN to honour in_unsigned; otherwise every conversion is signed.
module fpu_float_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_unsigned,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_nv,
  output logic        out_nx
);

  logic        s1_valid, s2_valid, s2_free;
  logic        s1_sign, s1_g, s1_st, s1_big, s1_nan;
  logic [32:0] s1_mag;
  logic [2:0]  s1_rm;

  assign s2_free   = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_free;
  assign out_valid = s2_valid;

  logic [7:0]  exp_b;
  logic [22:0] mant;
  logic [23:0] sig;
  logic [4:0]  shamt;
  logic [87:0] shifted;
  logic [32:0] c_mag;
  logic        c_g, c_st, c_big, c_nan;

  assign exp_b = in_data[30:23];
  assign mant  = in_data[22:0];
  assign sig   = {exp_b != 8'd0, mant};
  // Low five bits of E-127 for E in 127..158 equal E+1 modulo 32.
  assign shamt   = exp_b[4:0] + 5'd1;
  assign shifted = {32'd0, sig, 32'd0} << shamt;

  always_comb begin
    c_mag = '0;
    c_g   = 1'b0;
    c_st  = 1'b0;
    c_big = 1'b0;
    c_nan = 1'b0;
    if (exp_b == 8'd255) begin
      c_nan = (mant != 23'd0);
      c_big = (mant == 23'd0);
    end else if (exp_b >= 8'd159) begin
      c_big = 1'b1;
    end else if (exp_b >= 8'd127) begin
      // Binary point of the shifted word sits between bits 55 and 54.
      c_mag = shifted[87:55];
      c_g   = shifted[54];
      c_st  = |shifted[53:0];
    end else if (exp_b == 8'd126) begin
      c_g  = 1'b1;
      c_st = |mant;
    end else begin
      c_st = |sig;
    end
  end

`ifdef FPU_CVT_UNSIGNED_EN
  logic s1_uns;
`else
  logic unused_unsigned;
  assign unused_unsigned = in_unsigned;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_g     <= 1'b0;
      s1_st    <= 1'b0;
      s1_big   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_rm    <= '0;
`ifdef FPU_CVT_UNSIGNED_EN
      s1_uns   <= 1'b0;
`endif
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_data[31];
        s1_mag  <= c_mag;
        s1_g    <= c_g;
        s1_st   <= c_st;
        s1_big  <= c_big;
        s1_nan  <= c_nan;
        s1_rm   <= in_rm;
`ifdef FPU_CVT_UNSIGNED_EN
        s1_uns  <= in_unsigned;
`endif
      end
    end
  end

  logic        inc, inexact;
  logic [32:0] rounded;
  logic [31:0] sg_data, res_data;
  logic        sg_nv, res_nv;

  assign inexact = s1_g | s1_st;

  always_comb begin
    inc = 1'b0;
    case (s1_rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s1_sign & inexact;
      3'b011:  inc = !s1_sign & inexact;
      3'b100:  inc = s1_g;
      default: inc = s1_g & (s1_st | s1_mag[0]);
    endcase
  end

  assign rounded = s1_mag + {32'd0, inc};

  always_comb begin
    sg_data = '0;
    sg_nv   = 1'b1;
    if (s1_nan) begin
      sg_data = 32'h7FFF_FFFF;
    end else if (s1_big) begin
      sg_data = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (!s1_sign && rounded > 33'h0_7FFF_FFFF) begin
      sg_data = 32'h7FFF_FFFF;
    end else if (s1_sign && rounded > 33'h0_8000_0000) begin
      sg_data = 32'h8000_0000;
    end else begin
      sg_nv   = 1'b0;
      sg_data = s1_sign ? (32'd0 - rounded[31:0]) : rounded[31:0];
    end
  end

`ifdef FPU_CVT_UNSIGNED_EN
  logic [31:0] un_data;
  logic        un_nv;

  always_comb begin
    un_data = '0;
    un_nv   = 1'b1;
    if (s1_nan) begin
      un_data = 32'hFFFF_FFFF;
    end else if (s1_big) begin
      un_data = s1_sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
    end else if (!s1_sign && rounded[32]) begin
      un_data = 32'hFFFF_FFFF;
    end else if (s1_sign && rounded != 33'd0) begin
      un_data = 32'h0000_0000;
    end else begin
      un_nv   = 1'b0;
      un_data = s1_sign ? 32'd0 : rounded[31:0];
    end
  end

  assign res_data = s1_uns ? un_data : sg_data;
  assign res_nv   = s1_uns ? un_nv : sg_nv;
`else
  assign res_data = sg_data;
  assign res_nv   = sg_nv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_nv   <= 1'b0;
      out_nx   <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_data;
        out_nv   <= res_nv;
        out_nx   <= inexact & !res_nv;
      end
    end
  end

endmodule

// File: tb/tb_fpu_float_to_int.sv
// tb/tb_fpu_float_to_int.sv - directed self-checking bench for fpu_float_to_int
// Unsigned vectors are exercised only when FPU_CVT_UNSIGNED_EN is defined.
module tb_fpu_float_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_unsigned;
  logic [31:0] in_data, out_data;
  logic [2:0]  in_rm;
  logic        out_valid, out_ready, out_nv, out_nx;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] r;
    logic        nv;
    logic        nx;
  } vec_t;

  always #5 clk = ~clk;

  fpu_float_to_int dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_unsigned(in_unsigned), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nv(out_nv), .out_nx(out_nx)
  );

  task automatic convert(input logic [31:0] d, input logic [2:0] rm, input logic uns,
                         output logic [31:0] r, output logic nv, output logic nx, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_rm = rm; in_unsigned = uns; out_ready = 1'b1;
    #1;
    for (int w = 0; w < 10 && !in_ready; w++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = out_data; nv = out_nv; nx = out_nx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_nv !== 1'b0 || out_nx !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h nv=%b nx=%b required 0/0/0/0", out_valid, out_data, out_nv, out_nx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_rounding();
    vec_t tbl [14];
    logic [31:0] r; logic nv, nx; int lat;
    tbl = '{
      '{32'h3FC00000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h3FC00000, 3'd1, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'h40200000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h40200000, 3'd4, 1'b0, 32'h00000003, 1'b0, 1'b1},
      '{32'h40200000, 3'd3, 1'b0, 32'h00000003, 1'b0, 1'b1},
      '{32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1},
      '{32'hC0200000, 3'd3, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1},
      '{32'hC0200000, 3'd1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1},
      '{32'h40200000, 3'd7, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h3F000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1},
      '{32'h3F400000, 3'd0, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'h3F000000, 3'd4, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'h00000001, 3'd3, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'hBF800000, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      convert(tbl[i].d, tbl[i].rm, tbl[i].uns, r, nv, nx, lat);
      checks++;
      if (lat != 2 || r !== tbl[i].r || nv !== tbl[i].nv || nx !== tbl[i].nx) begin
        failures++;
        $display("FAIL rounding[%0d] in=%h rm=%0d: got data=%h nv=%b nx=%b lat=%0d required data=%h nv=%b nx=%b lat=2",
                 i, tbl[i].d, tbl[i].rm, r, nv, nx, lat, tbl[i].r, tbl[i].nv, tbl[i].nx);
      end
    end
  endtask

  task automatic test_saturation();
    vec_t tbl [11];
    logic [31:0] r; logic nv, nx; int lat;
    tbl = '{
      '{32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hCF000000, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0},
      '{32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hFFC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'h7F800000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hFF800000, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0},
      '{32'h4EFFFFFF, 3'd0, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0},
      '{32'hCF000001, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0},
      '{32'h80000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{32'h00000000, 3'd2, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{32'h4F800000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0}
    };
    foreach (tbl[i]) begin
      convert(tbl[i].d, tbl[i].rm, tbl[i].uns, r, nv, nx, lat);
      checks++;
      if (lat != 2 || r !== tbl[i].r || nv !== tbl[i].nv || nx !== tbl[i].nx) begin
        failures++;
        $display("FAIL saturation[%0d] in=%h: got data=%h nv=%b nx=%b lat=%0d required data=%h nv=%b nx=%b lat=2",
                 i, tbl[i].d, r, nv, nx, lat, tbl[i].r, tbl[i].nv, tbl[i].nx);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] r; logic nv, nx; int lat;
`ifdef FPU_CVT_UNSIGNED_EN
    vec_t tbl [10];
    tbl = '{
      '{32'h4F000000, 3'd0, 1'b1, 32'h80000000, 1'b0, 1'b0},
      '{32'hBF800000, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0},
      '{32'hBE800000, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'h7FC00000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
      '{32'h4F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
      '{32'hFF800000, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0},
      '{32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0},
      '{32'hBF400000, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0},
      '{32'hBF400000, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'h80000000, 3'd0, 1'b1, 32'h00000000, 1'b0, 1'b0}
    };
`else
    vec_t tbl [2];
    tbl = '{
      '{32'h4F000000, 3'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hBF800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0}
    };
`endif
    foreach (tbl[i]) begin
      convert(tbl[i].d, tbl[i].rm, tbl[i].uns, r, nv, nx, lat);
      checks++;
      if (lat != 2 || r !== tbl[i].r || nv !== tbl[i].nv || nx !== tbl[i].nx) begin
        failures++;
        $display("FAIL unsigned[%0d] in=%h: got data=%h nv=%b nx=%b lat=%0d required data=%h nv=%b nx=%b lat=2",
                 i, tbl[i].d, r, nv, nx, lat, tbl[i].r, tbl[i].nv, tbl[i].nx);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [4];
    logic [31:0] exp_r [4];
    int sent = 0, got = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    ops   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    exp_r = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready   = (cyc >= 3);
      in_valid    = (sent < 4);
      in_data     = (sent < 4) ? ops[sent] : 32'd0;
      in_rm       = 3'd0;
      in_unsigned = 1'b0;
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_stable cyc=%0d: valid=%b data=%h required 1/%h", cyc, out_valid, out_data, prev_data);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          failures++;
          $display("FAIL backpressure_ready: in_ready=%b accepted=%0d required 0/2", in_ready, sent);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== exp_r[got] || out_nv !== 1'b0 || out_nx !== 1'b0) begin
          failures++;
          $display("FAIL b2b_order[%0d]: data=%h nv=%b nx=%b required %h/0/0", got, out_data, out_nv, out_nx, exp_r[got]);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (got != 4 || sent != 4) begin
      failures++;
      $display("FAIL b2b_count: received=%0d accepted=%0d required 4/4", got, sent);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_no_duplicate cyc=%0d: out_valid=%b required 0", k, out_valid);
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] r; logic nv, nx; int lat;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7FC00000; in_rm = 3'd0; in_unsigned = 1'b0;
    @(negedge clk);
    in_data = 32'h4F000000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h7FFFFFFF || out_nv !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_before_reset: valid=%b data=%h nv=%b in_ready=%b required 1/7fffffff/1/0",
               out_valid, out_data, out_nv, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_nv !== 1'b0 || out_nx !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b data=%h nv=%b nx=%b required 0/0/0/0", out_valid, out_data, out_nv, out_nx);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_discard cyc=%0d: out_valid=%b in_ready=%b required 0/1", k, out_valid, in_ready);
      end
    end
    convert(32'h40200000, 3'd0, 1'b0, r, nv, nx, lat);
    checks++;
    if (lat != 2 || r !== 32'd2 || nv !== 1'b0 || nx !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_op: data=%h nv=%b nx=%b lat=%0d required 2/0/1/2", r, nv, nx, lat);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_unsigned = 1'b0; in_rm = '0; out_ready = 1'b0;
    test_reset();
    test_rounding();
    test_saturation();
    test_unsigned();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
